// File: rtl/composite_mixer.sv
// rtl/composite_mixer.sv - composite DAC mixer: aligned luma/flags, gated chroma, clamp, slew-limited sync
// Optional feature macro: COMPOSITE_MIXER_CLIP_COUNT_EN (saturating clipped-sample counter)
module composite_mixer #(
  parameter int CHROMA_LATENCY = 2,
  parameter int BLANK_LEVEL    = 72,
  parameter int SYNC_LEVEL     = 0,
  parameter int SLEW_STEP      = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  luma,
  input  logic [7:0]  chroma,
  input  logic        sync,
  input  logic        blank,
  input  logic        burst,
  input  logic        newframe,
  output logic [7:0]  dac_out,
  output logic [15:0] clip_count
);
  localparam logic [7:0]        BLANK_U = 8'(BLANK_LEVEL);
  localparam logic [7:0]        SYNC_U  = 8'(SYNC_LEVEL);
  localparam logic signed [9:0] BLANK_S = 10'(BLANK_LEVEL);
  localparam logic signed [9:0] SYNC_S  = 10'(SYNC_LEVEL);
  localparam logic signed [9:0] STEP_S  = 10'(SLEW_STEP);

  typedef enum logic [1:0] {ACTIVE, FALL, TIP, RISE} state_t;

  logic [7:0]                luma_dl [CHROMA_LATENCY];
  logic [CHROMA_LATENCY-1:0] sync_dl, blank_dl, burst_dl;

  // Taps reset to the blanked state so a mid-frame reset never exposes chroma or sync.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHROMA_LATENCY; i++) luma_dl[i] <= 8'd0;
      sync_dl  <= '0;
      blank_dl <= '1;
      burst_dl <= '0;
    end else begin
      luma_dl[0]  <= luma;
      sync_dl[0]  <= sync;
      blank_dl[0] <= blank;
      burst_dl[0] <= burst;
      for (int i = 1; i < CHROMA_LATENCY; i++) begin
        luma_dl[i]  <= luma_dl[i-1];
        sync_dl[i]  <= sync_dl[i-1];
        blank_dl[i] <= blank_dl[i-1];
        burst_dl[i] <= burst_dl[i-1];
      end
    end
  end

  logic [7:0] d_luma;
  logic       d_sync, d_blank, d_burst;
  assign d_luma  = luma_dl[CHROMA_LATENCY-1];
  assign d_sync  = sync_dl[CHROMA_LATENCY-1];
  assign d_blank = blank_dl[CHROMA_LATENCY-1];
  assign d_burst = burst_dl[CHROMA_LATENCY-1];

  logic              chroma_en, clipped;
  logic signed [9:0] base, sum, dn, up;
  logic [7:0]        target, fall_val, rise_val;

  always_comb begin
    chroma_en = ~d_sync & (d_burst | ~d_blank);
    base      = d_blank ? BLANK_S : BLANK_S + $signed({2'b00, d_luma});
    sum       = base + (chroma_en ? $signed({{2{chroma[7]}}, chroma}) : 10'sd0);
    clipped   = (sum < 10'sd0) || (sum > 10'sd255);
    if (sum < 10'sd0)        target = 8'd0;
    else if (sum > 10'sd255) target = 8'hFF;
    else                     target = sum[7:0];
    dn       = $signed({2'b00, dac_out}) - STEP_S;
    up       = $signed({2'b00, dac_out}) + STEP_S;
    fall_val = (dn <= SYNC_S)  ? SYNC_U  : dn[7:0];
    rise_val = (up >= BLANK_S) ? BLANK_U : up[7:0];
  end

  state_t     state, state_n;
  logic [7:0] dac_n;

  // Edge steps: landing exactly on the sync or blank level ends the edge in the same cycle.
  always_comb begin
    state_n = state;
    dac_n   = dac_out;
    case (state)
      ACTIVE: begin
        if (d_sync) begin
          dac_n   = fall_val;
          state_n = (fall_val == SYNC_U) ? TIP : FALL;
        end else begin
          dac_n = target;
        end
      end
      TIP: begin
        if (d_sync) begin
          dac_n = SYNC_U;
        end else begin
          dac_n   = rise_val;
          state_n = (rise_val == BLANK_U) ? ACTIVE : RISE;
        end
      end
      default: begin
        if (d_sync) begin
          dac_n   = fall_val;
          state_n = (fall_val == SYNC_U) ? TIP : FALL;
        end else begin
          dac_n   = rise_val;
          state_n = (rise_val == BLANK_U) ? ACTIVE : RISE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ACTIVE;
      dac_out <= BLANK_U;
    end else begin
      state   <= state_n;
      dac_out <= dac_n;
    end
  end

`ifdef COMPOSITE_MIXER_CLIP_COUNT_EN
  logic clip_inc;
  assign clip_inc = (state == ACTIVE) && !d_sync && clipped;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      clip_count <= 16'd0;
    else if (newframe)
      clip_count <= {15'd0, clip_inc};
    else if (clip_inc && clip_count != 16'hFFFF)
      clip_count <= clip_count + 16'd1;
  end
`else
  logic unused_clip;
  assign unused_clip = newframe ^ clipped;
  assign clip_count  = 16'd0;
`endif
endmodule

// File: tb/tb_composite_mixer.sv
// tb/tb_composite_mixer.sv - directed self-checking bench for composite_mixer
module tb_composite_mixer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  luma, chroma;
  logic        sync, blank, burst, newframe;
  logic [7:0]  dac_out;
  logic [15:0] clip_count;

  int passed = 0;
  int total  = 0;

`ifdef COMPOSITE_MIXER_CLIP_COUNT_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  composite_mixer dut (
    .clk(clk), .rst_n(rst_n), .luma(luma), .chroma(chroma), .sync(sync),
    .blank(blank), .burst(burst), .newframe(newframe),
    .dac_out(dac_out), .clip_count(clip_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int l, input int c, input logic s, input logic b, input logic bu);
    luma   = 8'(l);
    chroma = 8'(c);
    sync   = s;
    blank  = b;
    burst  = bu;
  endtask

  task automatic settle_blank();
    drive(0, 0, 1'b0, 1'b1, 1'b0);
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    newframe = 1'b0;
    drive(200, 50, 1'b0, 1'b1, 1'b0);
    repeat (3) tick();
    total++;
    if (dac_out !== 8'd72) $display("FAIL reset_dac_held: dac_out=%0d expected 72", dac_out);
    else passed++;
    total++;
    if (clip_count !== 16'd0) $display("FAIL reset_clip: clip_count=%0d expected 0", clip_count);
    else passed++;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (dac_out !== 8'd72) $display("FAIL reset_dac_after[%0d]: dac_out=%0d expected 72", i, dac_out);
      else passed++;
    end
  endtask

  task automatic test_active();
    drive(100, -20, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    total++;
    if (dac_out !== 8'd72) $display("FAIL active_latency_early: dac_out=%0d expected 72", dac_out);
    else passed++;
    tick();
    total++;
    if (dac_out !== 8'd152) $display("FAIL active_level: dac_out=%0d expected 152", dac_out);
    else passed++;
    chroma = 8'(10);
    tick();
    total++;
    if (dac_out !== 8'd182) $display("FAIL active_chroma_1cyc: dac_out=%0d expected 182", dac_out);
    else passed++;
  endtask

  task automatic test_sync_ramp();
    int exp_v [16];
    exp_v = '{72, 72, 48, 24, 0, 0, 0, 0, 0, 0, 0, 0, 24, 48, 72, 212};
    settle_blank();
    for (int k = 0; k < 16; k++) begin
      if (k < 10) drive(0, 40, 1'b1, 1'b1, 1'b0);
      else        drive(100, 40, 1'b0, 1'b0, 1'b0);
      tick();
      total++;
      if (dac_out !== 8'(exp_v[k]))
        $display("FAIL sync_ramp[%0d]: dac_out=%0d expected %0d", k, dac_out, exp_v[k]);
      else passed++;
    end
  endtask

  task automatic test_clamp();
    int l_v [17];
    int c_v [17];
    int nf_v [17];
    int dac_v [17];
    int clip_v [17];
    l_v    = '{200, 200, 200, 0, 0, 0, 50, 50, 50, 50, 50, 50, 183, 183, 183, 183, 183};
    c_v    = '{60, 60, 60, -100, -100, -100, 0, 0, 0, -128, -128, 0, 0, 0, 0, 1, 0};
    nf_v   = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    dac_v  = '{232, 232, 255, 172, 172, 0, 72, 72, 122, 0, 0, 122, 122, 122, 255, 255, 255};
    clip_v = '{0, 0, 1, 1, 1, 2, 2, 0, 0, 1, 2, 2, 2, 2, 2, 3, 3};
    for (int k = 0; k < 17; k++) begin
      drive(l_v[k], c_v[k], 1'b0, 1'b0, 1'b0);
      newframe = nf_v[k][0];
      tick();
      total++;
      if (dac_out !== 8'(dac_v[k]))
        $display("FAIL clamp_dac[%0d]: dac_out=%0d expected %0d", k, dac_out, dac_v[k]);
      else passed++;
      total++;
      if (clip_count !== (CLIP_EN ? 16'(clip_v[k]) : 16'd0))
        $display("FAIL clamp_clip[%0d]: clip_count=%0d expected %0d", k, clip_count,
                 CLIP_EN ? clip_v[k] : 0);
      else passed++;
    end
    newframe = 1'b0;
  endtask

  task automatic test_burst();
    int c_v [4];
    int e_v [4];
    c_v = '{30, -30, 30, -30};
    e_v = '{102, 42, 102, 42};
    drive(0, 0, 1'b0, 1'b1, 1'b1);
    repeat (3) tick();
    for (int k = 0; k < 4; k++) begin
      chroma = 8'(c_v[k]);
      tick();
      total++;
      if (dac_out !== 8'(e_v[k]))
        $display("FAIL burst[%0d]: dac_out=%0d expected %0d", k, dac_out, e_v[k]);
      else passed++;
    end
    drive(0, 30, 1'b0, 1'b1, 1'b0);
    repeat (3) tick();
    total++;
    if (dac_out !== 8'd72) $display("FAIL burst_off_blank: dac_out=%0d expected 72", dac_out);
    else passed++;
  endtask

  task automatic test_burst_sync();
    int s_v [12];
    int c_v [12];
    int e_v [12];
    s_v = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
    c_v = '{0, 0, 30, -30, 30, -30, 30, -30, 30, -30, 30, -30};
    e_v = '{72, 72, 48, 24, 0, 0, 0, 0, 24, 48, 72, 42};
    drive(0, 0, 1'b0, 1'b1, 1'b1);
    repeat (3) tick();
    for (int k = 0; k < 12; k++) begin
      drive(0, c_v[k], s_v[k][0], 1'b1, 1'b1);
      tick();
      total++;
      if (dac_out !== 8'(e_v[k]))
        $display("FAIL burst_sync[%0d]: dac_out=%0d expected %0d", k, dac_out, e_v[k]);
      else passed++;
    end
  endtask

  task automatic test_glitch();
    int e_v [5];
    e_v = '{72, 72, 48, 72, 92};
    settle_blank();
    for (int k = 0; k < 5; k++) begin
      if (k == 0) drive(0, 0, 1'b1, 1'b1, 1'b0);
      else        drive(20, 0, 1'b0, 1'b0, 1'b0);
      tick();
      total++;
      if (dac_out !== 8'(e_v[k]))
        $display("FAIL glitch[%0d]: dac_out=%0d expected %0d", k, dac_out, e_v[k]);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int s_v [11];
    int e_v [11];
    s_v = '{1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0};
    e_v = '{72, 72, 48, 24, 48, 24, 0, 24, 48, 72, 72};
    settle_blank();
    for (int k = 0; k < 11; k++) begin
      drive(0, 0, s_v[k][0], 1'b1, 1'b0);
      tick();
      total++;
      if (dac_out !== 8'(e_v[k]))
        $display("FAIL back_to_back[%0d]: dac_out=%0d expected %0d", k, dac_out, e_v[k]);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_edge();
    int e_v [3];
    e_v = '{72, 72, 48};
    settle_blank();
    drive(0, 0, 1'b1, 1'b1, 1'b0);
    repeat (4) tick();
    total++;
    if (dac_out !== 8'd24) $display("FAIL mid_edge_pre: dac_out=%0d expected 24", dac_out);
    else passed++;
    rst_n = 1'b0;
    #1;
    total++;
    if (dac_out !== 8'd72) $display("FAIL mid_edge_async: dac_out=%0d expected 72", dac_out);
    else passed++;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (dac_out !== 8'(e_v[k]))
        $display("FAIL mid_edge_flush[%0d]: dac_out=%0d expected %0d", k, dac_out, e_v[k]);
      else passed++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    newframe = 1'b0;
    drive(0, 0, 1'b0, 1'b1, 1'b0);
    test_reset();
    test_active();
    test_sync_ramp();
    test_clamp();
    test_burst();
    test_burst_sync();
    test_glitch();
    test_back_to_back();
    test_reset_mid_edge();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
